nf_byte_ctrl: RTL
=================

NF_BYTE_CTRL -- requirements
Module: nf_byte_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, flash byte-address width.
REQ-002 SHALL have parameter T_ACC, default 6, read-access cycles with NF_CE/NF_OE low (120 ns at 50 MHz).
REQ-003 SHALL have parameter T_WP, default 4, write-pulse cycles with NF_WE low.
REQ-004 SHALL have parameter T_WH, default 2, recovery cycles with NF_WE high between bus cycles.
REQ-005 SHALL have parameter STS_TIMEOUT, default 1000, maximum cycles spent polling NF_STS.
REQ-006 SHALL have port CLK_50MHZ, input, 1, sole clock, all logic on rising edge.
REQ-007 SHALL have port RST, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port RD_REQ, input, 1, byte read request from command path.
REQ-009 SHALL have port WR_REQ, input, 1, byte program request from command path.
REQ-010 SHALL have port ADDR, input, ADDR_W, request byte address.
REQ-011 SHALL have port WDATA, input, 8, byte to program.
REQ-012 SHALL have port BUSY, output, 1, high while a request is in progress.
REQ-013 SHALL have port RDATA, output, 8, last byte read.
REQ-014 SHALL have port RD_VALID, output, 1, one-cycle pulse, RDATA updated.
REQ-015 SHALL have port WR_DONE, output, 1, one-cycle pulse, program finished.
REQ-016 SHALL have port ERR, output, 1, one-cycle pulse, NF_STS poll timeout.
REQ-017 SHALL have ports NF_A out ADDR_W, NF_D inout 8, NF_CE/NF_OE/NF_WE out 1 (active-low strobes), NF_BYTE/NF_RP/NF_WP out 1, NF_STS in 1 (1 = flash ready).

Function
REQ-018 SHALL hold NF_BYTE=0 (byte mode) and NF_WP=1 permanently.
REQ-019 SHALL accept a request only in IDLE; RD_REQ wins over simultaneous WR_REQ; requests while BUSY=1 SHALL be ignored, not queued.
REQ-020 SHALL on acceptance register ADDR/WDATA, drive NF_A, and assert BUSY on the next cycle.
REQ-021 SHALL use states IDLE, RD_ACC, WR_CMD, WR_REC1, WR_DATA, WR_REC2, WR_POLL, WR_RDA, WR_REC3.
REQ-022 Read: RD_ACC holds NF_CE=NF_OE=0 for T_ACC cycles, samples NF_D on the last, then returns to IDLE with RD_VALID=1 and BUSY=0 in the same cycle.
REQ-023 Write bus cycle: NF_CE=NF_WE=0 for T_WP cycles with NF_D driven; NF_D SHALL stay driven through the following T_WH recovery cycles (NF_CE=NF_WE=1).
REQ-024 Write sequence: WR_CMD drives 0x40, WR_DATA drives WDATA, WR_POLL waits, WR_RDA drives 0xFF (read-array), WR_REC3 ends with WR_DONE=1, BUSY=0.
REQ-025 SHALL pass NF_STS through a two-flop synchronizer; WR_POLL exits on first synchronized 1.
REQ-026 SHALL on STS_TIMEOUT poll cycles without ready pulse ERR, skip WR_DONE, still perform the 0xFF cycle, leave RDATA unchanged.
REQ-027 NF_OE and NF_WE SHALL never be low in the same cycle; NF_D SHALL be high-Z whenever NF_OE=0 or in IDLE/RD_ACC.
REQ-028 All NF_* strobes SHALL come directly from flops (no glitches).
REQ-029 Counters SHALL be wide enough for the largest parameter and SHALL reload, not wrap, per state.

Reset
REQ-030 RST=1 SHALL asynchronously force: state IDLE, NF_CE=NF_OE=NF_WE=1, NF_D high-Z, NF_A=0, NF_RP=0, BUSY=RD_VALID=WR_DONE=ERR=0, RDATA=0x00.
REQ-031 NF_RP SHALL go to 1 on the first clock edge after RST release.
REQ-032 RST mid-operation SHALL abort the request without any done/valid/error pulse.

Verification
REQ-033 Read: flash model holds 0xA5 at 0x12; RD_REQ, ADDR=0x12 -> NF_OE low exactly 6 cycles, RD_VALID 1 cycle, RDATA=0xA5.
REQ-034 Program: WR_REQ, ADDR=0x34, WDATA=0x5A, NF_STS high after 20 cycles -> NF_D sequence 0x40, 0x5A, 0xFF, WR_DONE pulse; later read of 0x34 returns 0x5A.
REQ-035 Timeout: NF_STS held 0 -> ERR after 1000 poll cycles, 0xFF cycle issued, no WR_DONE.
REQ-036 Collision: RD_REQ and WR_REQ same cycle -> read only; WR_REQ during BUSY -> ignored.
REQ-037 Reset: RST pulse mid-WR_DATA -> strobes high, NF_D high-Z, NF_RP=0 immediately, no pulses afterwards.

Source files
------------

// File: rtl/nf_byte_ctrl.sv
// Byte-mode NOR flash controller: single-byte read, and word-program sequence
// (0x40 setup, data, status poll, 0xFF read-array) with a ready-poll timeout.
module nf_byte_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int T_ACC       = 6,
    parameter int T_WP        = 4,
    parameter int T_WH        = 2,
    parameter int STS_TIMEOUT = 1000
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              RD_REQ,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [7:0]        WDATA,
    output logic              BUSY,
    output logic [7:0]        RDATA,
    output logic              RD_VALID,
    output logic              WR_DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] NF_A,
    inout  wire  [7:0]        NF_D,
    output logic              NF_CE,
    output logic              NF_OE,
    output logic              NF_WE,
    output logic              NF_BYTE,
    output logic              NF_RP,
    output logic              NF_WP,
    input  logic              NF_STS
);

    localparam int MAX_AW = (T_ACC > T_WP) ? T_ACC : T_WP;
    localparam int MAX_HT = (T_WH > STS_TIMEOUT) ? T_WH : STS_TIMEOUT;
    localparam int MAX_T  = (MAX_AW > MAX_HT) ? MAX_AW : MAX_HT;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

    typedef enum logic [3:0] {
        IDLE,
        RD_ACC,
        WR_CMD,
        WR_REC1,
        WR_DATA,
        WR_REC2,
        WR_POLL,
        WR_RDA,
        WR_REC3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_zero;
    logic             accept;
    logic             rd_done;
    logic             wr_fin;
    logic             timeout;
    logic             to_q;
    logic             sts_p0, sts_p1;
    logic             nf_d_oe;
    logic [7:0]       nf_d_out;
    logic [7:0]       wdata_q;

    // Dwell time of each state, expressed as the counter reload value.
    function automatic logic [CNT_W-1:0] load_cnt(input state_t s);
        case (s)
            RD_ACC:                   load_cnt = CNT_W'(T_ACC - 1);
            WR_CMD, WR_DATA, WR_RDA:  load_cnt = CNT_W'(T_WP - 1);
            WR_REC1, WR_REC2, WR_REC3: load_cnt = CNT_W'(T_WH - 1);
            WR_POLL:                  load_cnt = CNT_W'(STS_TIMEOUT - 1);
            default:                  load_cnt = '0;
        endcase
    endfunction

    function automatic logic is_we_pulse(input state_t s);
        return s inside {WR_CMD, WR_DATA, WR_RDA};
    endfunction

    function automatic logic is_driving(input state_t s);
        return s inside {WR_CMD, WR_REC1, WR_DATA, WR_REC2, WR_RDA, WR_REC3};
    endfunction

    assign NF_BYTE  = 1'b0;
    assign NF_WP    = 1'b1;
    assign NF_D     = nf_d_oe ? nf_d_out : 8'hzz;
    assign cnt_zero = (cnt == '0);
    assign accept   = (state == IDLE) && (RD_REQ || WR_REQ);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_done   = 1'b0;
        wr_fin    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (RD_REQ)      state_nxt = RD_ACC;
                else if (WR_REQ) state_nxt = WR_CMD;
            end
            RD_ACC: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    rd_done   = 1'b1;
                end
            end
            WR_CMD:  if (cnt_zero) state_nxt = WR_REC1;
            WR_REC1: if (cnt_zero) state_nxt = WR_DATA;
            WR_DATA: if (cnt_zero) state_nxt = WR_REC2;
            WR_REC2: if (cnt_zero) state_nxt = WR_POLL;
            WR_POLL: begin
                if (sts_p1) begin
                    state_nxt = WR_RDA;
                end else if (cnt_zero) begin
                    state_nxt = WR_RDA;
                    timeout   = 1'b1;
                end
            end
            WR_RDA:  if (cnt_zero) state_nxt = WR_REC3;
            WR_REC3: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    wr_fin    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Every state entry reloads the counter, so it never wraps.
        if (state_nxt != state)
            cnt_nxt = load_cnt(state_nxt);
        else if (!cnt_zero)
            cnt_nxt = cnt - CNT_W'(1);
    end

    // Strobes and status are registered from the next state so the pins
    // change in the same cycle the state does and never glitch.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            BUSY     <= 1'b0;
            RD_VALID <= 1'b0;
            WR_DONE  <= 1'b0;
            ERR      <= 1'b0;
            RDATA    <= 8'h00;
            NF_A     <= '0;
            NF_CE    <= 1'b1;
            NF_OE    <= 1'b1;
            NF_WE    <= 1'b1;
            NF_RP    <= 1'b0;
            nf_d_oe  <= 1'b0;
            to_q     <= 1'b0;
            sts_p0   <= 1'b0;
            sts_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            BUSY     <= (state_nxt != IDLE);
            RD_VALID <= rd_done;
            WR_DONE  <= wr_fin && !to_q;
            ERR      <= timeout;
            NF_CE    <= !((state_nxt == RD_ACC) || is_we_pulse(state_nxt));
            NF_OE    <= (state_nxt != RD_ACC);
            NF_WE    <= !is_we_pulse(state_nxt);
            NF_RP    <= 1'b1;
            nf_d_oe  <= is_driving(state_nxt);
            sts_p0   <= NF_STS;
            sts_p1   <= sts_p0;
            if (rd_done)
                RDATA <= NF_D;
            if (accept) begin
                NF_A <= ADDR;
                to_q <= 1'b0;
            end else if (timeout) begin
                to_q <= 1'b1;
            end
        end
    end

    // Data path registers carry no reset: the bus is tri-stated until used.
    always_ff @(posedge CLK_50MHZ) begin
        if (accept)
            wdata_q <= WDATA;
        case (state_nxt)
            WR_CMD, WR_REC1: nf_d_out <= 8'h40;
            WR_DATA, WR_REC2: nf_d_out <= wdata_q;
            WR_RDA, WR_REC3: nf_d_out <= 8'hFF;
            default:         nf_d_out <= nf_d_out;
        endcase
    end

endmodule
